// File: rtl/mutex_pkg.sv
// mutex_pkg: shared types and default constants for the mutex request front end.
// Optional feature macro used by the importing modules: GRANT_TIMEOUT_EN.
package mutex_pkg;

    localparam int NUM_REQ_DEF     = 5;
    localparam int MAX_HOLD_DEF    = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } chan_state_t;

endpackage

// File: rtl/mutex_chan_fsm.sv
// mutex_chan_fsm: one client channel of the mutex front end. Holds the grant
// synchroniser, the four-phase handshake FSM, the ownership hold counter and,
// when GRANT_TIMEOUT_EN is defined, the request timeout counter.
module mutex_chan_fsm
    import mutex_pkg::*;
#(
    parameter int MAX_HOLD    = MAX_HOLD_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef GRANT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic cli_req,
    input  logic cli_rel,
    input  logic arb_grant,
    output logic cli_gnt,
    output logic cli_force,
    output logic arb_req,
    output logic gnt_s,
    output logic active
`ifdef GRANT_TIMEOUT_EN
    ,
    output logic cli_timeout
`endif
);

    localparam int HOLD_W = $clog2(MAX_HOLD);

    chan_state_t             state;
    chan_state_t             next_state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    hold_done;
    logic                    arb_req_d;
    logic                    force_d;

`ifdef GRANT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0]        req_cnt;
    logic                    tmo_done;
    logic                    tmo_d;
`endif

    assign gnt_s     = sync_q[SYNC_STAGES-1];
    assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Shift the asynchronous grant through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], arb_grant};
        end
    end

    // State register for the handshake FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ownership counter: held at zero outside OWN so every entry starts from 0, saturates at expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != OWN) begin
            hold_cnt <= '0;
        end else if (!hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

`ifdef GRANT_TIMEOUT_EN
    assign tmo_done = (req_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Request-wait counter: held at zero outside REQ, saturates at the timeout value.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt <= '0;
        end else if (state != REQ) begin
            req_cnt <= '0;
        end else if (!tmo_done) begin
            req_cnt <= req_cnt + TMO_W'(1);
        end
    end
`endif

    // Next-state logic: grant wins over abandon, and a client release wins over hold expiry.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cli_req) next_state = REQ;
            end
            REQ: begin
                if (gnt_s) begin
                    next_state = OWN;
                end else if (!cli_req) begin
                    next_state = REL;
                end
`ifdef GRANT_TIMEOUT_EN
                else if (tmo_done) begin
                    next_state = REL;
                end
`endif
            end
            OWN: begin
                if (cli_rel || hold_done) next_state = REL;
            end
            REL: begin
                if (!gnt_s) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: arb_req and the pulses are precomputed here and registered below.
    always_comb begin
        arb_req_d = (next_state == REQ) || (next_state == OWN);
        force_d   = (state == OWN) && !cli_rel && hold_done;
        cli_gnt   = (state == OWN);
        active    = (state != IDLE);
`ifdef GRANT_TIMEOUT_EN
        tmo_d     = (state == REQ) && !gnt_s && cli_req && tmo_done;
`endif
    end

    // Output registers so the arbiter X line and the pulses come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_req     <= 1'b0;
            cli_force   <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            cli_timeout <= 1'b0;
`endif
        end else begin
            arb_req     <= arb_req_d;
            cli_force   <= force_d;
`ifdef GRANT_TIMEOUT_EN
            cli_timeout <= tmo_d;
`endif
        end
    end

endmodule

// File: rtl/mutex_req_ctrl.sv
// mutex_req_ctrl: synchronous client front end for the 5-way mutex arbiter.
// One mutex_chan_fsm per client, plus the sticky mutual-exclusion check and busy flag.
// Optional feature macro: GRANT_TIMEOUT_EN adds the cli_timeout port and REQ timeout.
module mutex_req_ctrl
    import mutex_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int MAX_HOLD    = MAX_HOLD_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef GRANT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] cli_req,
    input  logic [NUM_REQ-1:0] cli_rel,
    output logic [NUM_REQ-1:0] cli_gnt,
    output logic [NUM_REQ-1:0] cli_force,
    output logic [NUM_REQ-1:0] arb_req,
    input  logic [NUM_REQ-1:0] arb_grant,
    output logic               mutex_err,
    output logic               busy
`ifdef GRANT_TIMEOUT_EN
    ,
    output logic [NUM_REQ-1:0] cli_timeout
`endif
);

    localparam int CNT_W = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0] gnt_s;
    logic [NUM_REQ-1:0] chan_active;
    logic [CNT_W-1:0]   gnt_count;
    logic               multi_now;
    logic               err_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        mutex_chan_fsm #(
            .MAX_HOLD    (MAX_HOLD),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef GRANT_TIMEOUT_EN
            ,
            .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cli_req     (cli_req[i]),
            .cli_rel     (cli_rel[i]),
            .arb_grant   (arb_grant[i]),
            .cli_gnt     (cli_gnt[i]),
            .cli_force   (cli_force[i]),
            .arb_req     (arb_req[i]),
            .gnt_s       (gnt_s[i]),
            .active      (chan_active[i])
`ifdef GRANT_TIMEOUT_EN
            ,
            .cli_timeout (cli_timeout[i])
`endif
        );
    end

    // Population count of the synchronised grants; more than one is a mutex violation.
    always_comb begin
        gnt_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_count = gnt_count + CNT_W'(gnt_s[i]);
        end
        multi_now = (gnt_count > CNT_W'(1));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (multi_now) begin
            err_q <= 1'b1;
        end
    end

    // The flag shows in the same cycle the double grant appears on gnt_s, then holds.
    assign mutex_err = err_q | multi_now;

    // Registered busy: any channel outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= |chan_active;
        end
    end

endmodule

// File: tb/tb_mutex_req_ctrl.sv
// tb_mutex_req_ctrl: directed scoreboard bench for mutex_req_ctrl.
// Stimulus pushes timed expectations into a queue; a monitor on the falling edge
// pops the ones due in the current cycle and compares them with the DUT outputs.
// Define GRANT_TIMEOUT_EN to build and exercise the request timeout.
module tb_mutex_req_ctrl;

    localparam int NUM_REQ = 5;

    typedef enum {S_ARB, S_GNT, S_FORCE, S_ERR, S_BUSY, S_TMO} sig_e;

    typedef struct {
        int                 cyc;
        sig_e               sig;
        logic [NUM_REQ-1:0] val;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] cli_req;
    logic [NUM_REQ-1:0] cli_rel;
    logic [NUM_REQ-1:0] cli_gnt;
    logic [NUM_REQ-1:0] cli_force;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic               mutex_err;
    logic               busy;
`ifdef GRANT_TIMEOUT_EN
    logic [NUM_REQ-1:0] cli_timeout;
`endif

    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    mutex_req_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cli_req     (cli_req),
        .cli_rel     (cli_rel),
        .cli_gnt     (cli_gnt),
        .cli_force   (cli_force),
        .arb_req     (arb_req),
        .arb_grant   (arb_grant),
        .mutex_err   (mutex_err),
        .busy        (busy)
`ifdef GRANT_TIMEOUT_EN
        ,
        .cli_timeout (cli_timeout)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: cyc is the number of rising edges seen so far.
    always @(posedge clk) cyc = cyc + 1;

    // Hard stop in case the timeline ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, required finish earlier", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitCycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] req,
                                 input logic [NUM_REQ-1:0] rel, input logic [NUM_REQ-1:0] gnt);
        rst       = r;
        cli_req   = req;
        cli_rel   = rel;
        arb_grant = gnt;
    endtask

    task automatic expectAt(input int c, input sig_e s, input logic [NUM_REQ-1:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [NUM_REQ-1:0] act;
        case (e.sig)
            S_ARB:   act = arb_req;
            S_GNT:   act = cli_gnt;
            S_FORCE: act = cli_force;
            S_ERR:   act = {{(NUM_REQ-1){1'b0}}, mutex_err};
            S_BUSY:  act = {{(NUM_REQ-1){1'b0}}, busy};
`ifdef GRANT_TIMEOUT_EN
            S_TMO:   act = cli_timeout;
`endif
            default: act = 'x;
        endcase
        tests = tests + 1;
        if (act !== e.val) begin
            failed = failed + 1;
            $display("[TB] FAIL %s @cyc %0d: got %b, expected %b", e.sig.name(), cyc, act, e.val);
        end
    endtask

    // Monitor: on each falling edge compare every expectation due this cycle.
    always @(negedge clk) begin : monitor
        exp_t keep[$];
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i]);
            end else if (sb[i].cyc < cyc) begin
                tests  = tests + 1;
                failed = failed + 1;
                $display("[TB] FAIL %s missed: due cyc %0d, now %0d", sb[i].sig.name(), sb[i].cyc, cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    // Directed timeline; every expected value below is hand-derived from the cycle at which it is due.
    initial begin
        applyStimulus(1'b1, 5'b11111, 5'b00000, 5'b00000);

        // Reset with all requests high: everything cleared, then all request on the first edge out.
        waitCycle(3);
        expectAt(3, S_ARB,   5'b00000);
        expectAt(3, S_GNT,   5'b00000);
        expectAt(3, S_FORCE, 5'b00000);
        expectAt(3, S_ERR,   5'b00000);
        expectAt(3, S_BUSY,  5'b00000);
        applyStimulus(1'b0, 5'b11111, 5'b00000, 5'b00000);
        expectAt(4, S_ARB,   5'b11111);
        expectAt(5, S_ARB,   5'b00000);
        expectAt(5, S_BUSY,  5'b00001);
        expectAt(7, S_BUSY,  5'b00000);
        waitCycle(4);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00000);

        // Single client 0: grant, release, REL until grant falls, then re-request.
        waitCycle(10);
        applyStimulus(1'b0, 5'b00001, 5'b00000, 5'b00000);
        expectAt(11, S_ARB, 5'b00001);
        waitCycle(11);
        applyStimulus(1'b0, 5'b00001, 5'b00000, 5'b00001);
        expectAt(13, S_GNT, 5'b00000);
        expectAt(14, S_GNT, 5'b00001);
        expectAt(14, S_ARB, 5'b00001);
        waitCycle(16);
        applyStimulus(1'b0, 5'b00001, 5'b00001, 5'b00001);
        expectAt(17, S_ARB,   5'b00000);
        expectAt(17, S_GNT,   5'b00000);
        expectAt(17, S_FORCE, 5'b00000);
        waitCycle(17);
        applyStimulus(1'b0, 5'b00001, 5'b00000, 5'b00000);
        expectAt(19, S_ARB,  5'b00000);
        expectAt(20, S_ARB,  5'b00000);
        expectAt(20, S_BUSY, 5'b00001);
        expectAt(21, S_BUSY, 5'b00000);
        expectAt(21, S_ARB,  5'b00001);
        waitCycle(21);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00000);
        expectAt(22, S_ARB, 5'b00000);

        // Forced release on client 2: force pulse 16 cycles after grant, with arb_req drop.
        waitCycle(30);
        applyStimulus(1'b0, 5'b00100, 5'b00000, 5'b00000);
        expectAt(31, S_ARB, 5'b00100);
        waitCycle(31);
        applyStimulus(1'b0, 5'b00100, 5'b00000, 5'b00100);
        expectAt(33, S_GNT,   5'b00000);
        expectAt(34, S_GNT,   5'b00100);
        expectAt(49, S_GNT,   5'b00100);
        expectAt(49, S_ARB,   5'b00100);
        expectAt(49, S_FORCE, 5'b00000);
        expectAt(50, S_FORCE, 5'b00100);
        expectAt(50, S_ARB,   5'b00000);
        expectAt(50, S_GNT,   5'b00000);
        expectAt(51, S_FORCE, 5'b00000);
        expectAt(53, S_BUSY,  5'b00001);
        expectAt(54, S_BUSY,  5'b00000);
        waitCycle(35);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00100);
        waitCycle(50);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00000);

        // Abandon on client 3 with the synchronised grant arriving in REL.
        waitCycle(60);
        applyStimulus(1'b0, 5'b01000, 5'b00000, 5'b00000);
        expectAt(61, S_ARB, 5'b01000);
        waitCycle(61);
        applyStimulus(1'b0, 5'b01000, 5'b00000, 5'b01000);
        expectAt(62, S_ARB, 5'b01000);
        waitCycle(62);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b01000);
        expectAt(63, S_ARB,  5'b00000);
        expectAt(63, S_GNT,  5'b00000);
        expectAt(64, S_GNT,  5'b00000);
        expectAt(66, S_GNT,  5'b00000);
        expectAt(68, S_GNT,  5'b00000);
        expectAt(68, S_ARB,  5'b00000);
        expectAt(69, S_ARB,  5'b00000);
        expectAt(69, S_BUSY, 5'b00001);
        expectAt(70, S_ARB,  5'b01000);
        expectAt(70, S_GNT,  5'b00000);
        expectAt(73, S_BUSY, 5'b00000);
        waitCycle(64);
        applyStimulus(1'b0, 5'b01000, 5'b00000, 5'b01000);
        waitCycle(66);
        applyStimulus(1'b0, 5'b01000, 5'b00000, 5'b00000);
        waitCycle(70);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00000);

        // Client 4 requests and is never granted.
        waitCycle(80);
        applyStimulus(1'b0, 5'b10000, 5'b00000, 5'b00000);
        expectAt(81,  S_ARB, 5'b10000);
        expectAt(144, S_ARB, 5'b10000);
`ifdef GRANT_TIMEOUT_EN
        expectAt(144, S_TMO, 5'b00000);
        expectAt(145, S_TMO, 5'b10000);
        expectAt(145, S_ARB, 5'b00000);
        expectAt(146, S_TMO, 5'b00000);
`else
        expectAt(145, S_ARB, 5'b10000);
`endif
        waitCycle(145);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00000);

        // Mutex violation: two grants at once set the sticky flag until reset.
        expectAt(159, S_ERR, 5'b00000);
        waitCycle(160);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00110);
        expectAt(161, S_ERR, 5'b00000);
        expectAt(162, S_ERR, 5'b00001);
        expectAt(166, S_ERR, 5'b00001);
        waitCycle(162);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00000);
        waitCycle(166);
        applyStimulus(1'b1, 5'b00000, 5'b00000, 5'b00000);
        expectAt(167, S_ERR, 5'b00000);
        waitCycle(167);
        applyStimulus(1'b0, 5'b00000, 5'b00000, 5'b00000);
        expectAt(168, S_ERR,  5'b00000);
        expectAt(168, S_BUSY, 5'b00000);
        expectAt(168, S_ARB,  5'b00000);

        waitCycle(172);
        foreach (sb[i]) begin
            tests  = tests + 1;
            failed = failed + 1;
            $display("[TB] FAIL %s never checked: due cyc %0d", sb[i].sig.name(), sb[i].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mutex_req_ctrl.md
Name: mutex_req_ctrl

Overview:
- Synchronous client-side front end for the 5-way mutex arbiter; sits directly upstream of it.
- Converts per-client level requests into a four-phase req/grant handshake on the arbiter's X/Y lines.
- Synchronises the asynchronous grants into the clock domain.
- Enforces a maximum ownership time and flags any mutual-exclusion violation seen on the grants.

Parameters:
- NUM_REQ, 5, number of clients/arbiter channels.
- MAX_HOLD, 16, max cycles a client may stay in OWN before forced release (>=2).
- SYNC_STAGES, 2, flops in each grant synchroniser (>=2).
- TIMEOUT_CYC, 64, cycles allowed in REQ before abort (used only with GRANT_TIMEOUT_EN).

Ports:
- clk, in, 1, single clock.
- rst, in, 1, reset, synchronous, active-high.
- cli_req, in, NUM_REQ, per-client access request (level); held until cli_gnt or abandoned.
- cli_rel, in, NUM_REQ, per-client release request; sampled only in OWN.
- cli_gnt, out, NUM_REQ, client owns the shared resource.
- cli_force, out, NUM_REQ, 1-cycle pulse: MAX_HOLD expired, release forced.
- arb_req, out, NUM_REQ, to arbiter X inputs; registered.
- arb_grant, in, NUM_REQ, from arbiter Y outputs; asynchronous.
- mutex_err, out, 1, sticky: more than one synchronised grant high in the same cycle.
- busy, out, 1, OR of all channels not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): all channels go to IDLE. Outputs cleared: arb_req=0, cli_gnt=0, cli_force=0, mutex_err=0, busy=0. Sync flops and hold counters cleared.
- Reset mid-operation drops arb_req the next edge without waiting for the grant to fall. The arbiter releases by itself.
- Grant sync: gnt_s[i] is arb_grant[i] delayed by SYNC_STAGES flops. Only gnt_s is used by the logic.
- Per-channel FSM, one independent instance per client, 2-bit state:
  - IDLE (0): arb_req=0. If cli_req=1, go to REQ.
  - REQ (1): arb_req=1.
    - gnt_s=1: go to OWN.
    - Else if cli_req=0 (abandon): go to REL.
  - OWN (2): arb_req=1, cli_gnt=1, hold_cnt increments each cycle starting from 0.
    - cli_rel=1: go to REL.
    - Else if hold_cnt==MAX_HOLD-1: go to REL and pulse cli_force.
    - cli_rel and expiry in the same cycle: normal release, no cli_force.
  - REL (3): arb_req=0. Wait for gnt_s=0, then go to IDLE.
    - A stale grant after an abandon is absorbed here.
    - cli_req is ignored while in REL.
- Latency, with SYNC_STAGES=2:
  - cli_req high at edge n gives arb_req=1 after edge n+1.
  - arb_grant rising gives cli_gnt=1 three edges later (two sync flops plus the state register).
- Re-request: after REL to IDLE, if cli_req is still high, REQ is entered next cycle. There is no back-to-back OWN without a release cycle.
- mutex_err: set when popcount(gnt_s)>1. Cleared only by rst.
- busy: registered OR of (state!=IDLE) across all channels.
- Width rule: hold_cnt is $clog2(MAX_HOLD) bits and never wraps; it is reset to 0 on entry to OWN.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- When defined:
  - Each channel counts cycles in REQ.
  - At TIMEOUT_CYC-1 without gnt_s, the channel goes to REL.
  - It also raises a 1-cycle pulse on added output port cli_timeout[NUM_REQ-1:0].
- When undefined: REQ waits indefinitely; the cli_timeout port and counter are absent.

Decomposition:
- Shared package mutex_pkg holds:
  - The state typedef, with encodings IDLE=0, REQ=1, OWN=2, REL=3.
  - The default constants for NUM_REQ, MAX_HOLD and SYNC_STAGES.
- Sub-module mutex_chan_fsm, one channel: synchroniser, FSM, hold counter and optional timeout.
- The top instantiates it NUM_REQ times. The top also holds the popcount-based mutex_err logic and the busy OR.

Test Plan:
- Reset check: rst=1 with cli_req=5'b11111 → arb_req, cli_gnt, mutex_err, busy all 0. After rst drops, arb_req=5'b11111 at the first edge.
- Single client: cli_req=5'b00001; model arbiter grants Y0 when arb_req[0] rises.
  - cli_gnt[0]=1 three edges after the grant.
  - cli_rel[0] pulse → arb_req[0]=0 next edge.
  - After the grant falls, REL to IDLE.
- Forced release, MAX_HOLD=16: client 2 granted, never asserts cli_rel.
  - cli_force[2] pulses exactly 16 cycles after cli_gnt[2] rose.
  - arb_req[2] goes 0 at the same time.
- Abandon with stale grant: cli_req[3] goes high then low in REQ, and arb_grant[3] rises during REL.
  - cli_gnt[3] never asserts.
  - The channel stays in REL until the grant falls, then returns to IDLE.
- Mutex violation: force arb_grant=5'b00110.
  - mutex_err=1 two edges later and stays 1 after the grants clear.
  - It clears only on rst.
- With GRANT_TIMEOUT_EN, TIMEOUT_CYC=64: cli_req[4]=1, arbiter never grants.
  - cli_timeout[4] pulses 64 cycles after REQ entry.
  - arb_req[4] drops at the same edge.
